// File: rtl/alarm_controller.sv
// alarm_controller: multi-channel alarm block.
// Each channel debounces a raw sensor, latches an alarm and waits for its own
// acknowledge. A fixed-priority encoder reports the lowest active channel, and
// a shared siren blinks while any alarm is unacknowledged.
// Optional feature: define ALARM_TIMEOUT_EN to auto-acknowledge a channel that
// stays ACTIVE for TIMEOUT cycles.
module alarm_controller #(
  parameter int NUM_ALARMS = 3,
  parameter int DEBOUNCE   = 4,
  parameter int BLINK_HALF = 2,
  parameter int ID_W       = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic [NUM_ALARMS-1:0] sensor,
  input  logic [NUM_ALARMS-1:0] ack,
  output logic [NUM_ALARMS-1:0] alarm,
  output logic                  any_alarm,
  output logic [ID_W-1:0]       top_id,
  output logic                  siren
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACTIVE  = 2'd2,
    ACKED   = 2'd3
  } state_t;

  // One counter per channel serves both debounce and timeout, so it is sized
  // for the larger of the two terminal counts in every build.
  localparam int CNT_MAX = (TIMEOUT > DEBOUNCE) ? TIMEOUT : DEBOUNCE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BCNT_W  = $clog2(BLINK_HALF) + 1;

  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE - 1);
`ifdef ALARM_TIMEOUT_EN
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);
`endif
  localparam logic [BCNT_W-1:0] BH_LAST  = BCNT_W'(BLINK_HALF - 1);

  state_t           state      [NUM_ALARMS];
  state_t           next_state [NUM_ALARMS];
  logic [CNT_W-1:0] cnt        [NUM_ALARMS];
  logic [CNT_W-1:0] next_cnt   [NUM_ALARMS];
  logic [BCNT_W-1:0] bcnt;

  // State register: channel FSMs, counters and the registered alarm vector.
  // NOTE: the per-channel arrays are control state, not storage, so every
  // element is explicitly reset; they must never power up mid-sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      alarm <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the
      // pre-edge values, independent of statement order.
      for (int i = 0; i < NUM_ALARMS; i++) begin
        state[i] <= next_state[i];
        cnt[i]   <= next_cnt[i];
        alarm[i] <= (next_state[i] == ACTIVE);
      end
    end
  end

  // Next-state logic for every channel; arm=0 overrides everything.
  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      // NOTE: hold-by-default assignments first, so no path leaves a signal
      // unassigned and no latch is inferred.
      next_state[i] = state[i];
      next_cnt[i]   = cnt[i];
      if (!arm) begin
        next_state[i] = IDLE;
        next_cnt[i]   = '0;
      end else begin
        case (state[i])
          IDLE: begin
            if (sensor[i]) begin
              next_state[i] = PENDING;
              next_cnt[i]   = CNT_W'(1);
            end
          end
          PENDING: begin
            if (!sensor[i]) begin
              next_state[i] = IDLE;
              next_cnt[i]   = '0;
            end else if (cnt[i] == DEB_LAST) begin
              next_state[i] = ACTIVE;
              next_cnt[i]   = '0;
            end else begin
              next_cnt[i] = cnt[i] + CNT_W'(1);
            end
          end
          ACTIVE: begin
`ifdef ALARM_TIMEOUT_EN
            if (ack[i] || (cnt[i] == TO_LAST)) begin
              next_state[i] = sensor[i] ? ACKED : IDLE;
              next_cnt[i]   = '0;
            end else begin
              next_cnt[i] = cnt[i] + CNT_W'(1);
            end
`else
            if (ack[i]) begin
              next_state[i] = sensor[i] ? ACKED : IDLE;
              next_cnt[i]   = '0;
            end
`endif
          end
          ACKED: begin
            // A sensor still high after acknowledge must fall before it can
            // raise a new alarm.
            if (!sensor[i]) begin
              next_state[i] = IDLE;
              next_cnt[i]   = '0;
            end
          end
          default: begin
            next_state[i] = IDLE;
            next_cnt[i]   = '0;
          end
        endcase
      end
    end
  end

  // Output decode: summary flag and fixed-priority encoder (lowest index wins).
  always_comb begin
    any_alarm = |alarm;
    top_id    = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (alarm[i]) top_id = ID_W'(i);
    end
  end

  // Siren blinker: half-period BLINK_HALF, silent whenever no alarm is up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      siren <= 1'b0;
      bcnt  <= '0;
    end else if (!any_alarm) begin
      siren <= 1'b0;
      bcnt  <= '0;
    end else if (bcnt == BH_LAST) begin
      siren <= ~siren;
      bcnt  <= '0;
    end else begin
      bcnt <= bcnt + BCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed self-checking bench for alarm_controller with default parameters
// (NUM_ALARMS=3, DEBOUNCE=4, BLINK_HALF=2, TIMEOUT=16).
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       arm;
  logic [2:0] sensor;
  logic [2:0] ack;
  logic [2:0] alarm;
  logic       any_alarm;
  logic [1:0] top_id;
  logic       siren;

  int checks   = 0;
  int failures = 0;

  alarm_controller dut (
    .clk       (clk),
    .reset     (reset),
    .arm       (arm),
    .sensor    (sensor),
    .ack       (ack),
    .alarm     (alarm),
    .any_alarm (any_alarm),
    .top_id    (top_id),
    .siren     (siren)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    arm    = 1'b0;
    sensor = 3'b000;
    ack    = 3'b000;
    tick(2);
    check("reset_alarm", 32'(alarm), 32'h0);
    check("reset_siren", 32'(siren), 32'h0);
    check("reset_any", 32'(any_alarm), 32'h0);
    check("reset_top", 32'(top_id), 32'h0);
    reset = 1'b1;
    arm   = 1'b1;
    tick(1);

    // Debounce rejection: 3 high samples then low never alarms.
    sensor = 3'b001;
    tick(3);
    check("glitch_3edges", 32'(alarm), 32'h0);
    sensor = 3'b000;
    tick(2);
    check("glitch_after", 32'(alarm), 32'h0);
    check("glitch_siren", 32'(siren), 32'h0);

    // Debounce and latch on channel 1.
    sensor = 3'b010;
    tick(3);
    check("latch_edge3", 32'(alarm), 32'h0);
    tick(1);
    check("latch_edge4", 32'(alarm), 32'h2);
    check("latch_top", 32'(top_id), 32'h1);
    check("latch_any", 32'(any_alarm), 32'h1);
    sensor = 3'b000;
    tick(2);
    check("latch_hold", 32'(alarm), 32'h2);
    // Clear it with ack while the sensor is low -> IDLE.
    ack = 3'b010;
    tick(1);
    check("ack_to_idle", 32'(alarm), 32'h0);
    ack = 3'b000;
    tick(1);
    check("siren_off", 32'(siren), 32'h0);

    // Priority and siren timing.
    sensor = 3'b110;
    tick(4);
    check("prio_alarm", 32'(alarm), 32'h6);
    check("prio_top", 32'(top_id), 32'h1);
    check("siren_a0", 32'(siren), 32'h0);
    tick(1);
    check("siren_a1", 32'(siren), 32'h0);
    tick(1);
    check("siren_a2", 32'(siren), 32'h1);
    tick(1);
    check("siren_a3", 32'(siren), 32'h1);
    tick(1);
    check("siren_a4", 32'(siren), 32'h0);
    sensor = 3'b111;
    tick(3);
    check("prio_edge3", 32'(alarm), 32'h6);
    check("siren_a7", 32'(siren), 32'h1);
    tick(1);
    check("prio_all", 32'(alarm), 32'h7);
    check("prio_top0", 32'(top_id), 32'h0);

    // Acknowledge: clear channels 1,2 to IDLE, then ack channel 0 into ACKED.
    sensor = 3'b001;
    ack    = 3'b110;
    tick(1);
    check("ack_partial", 32'(alarm), 32'h1);
    ack = 3'b001;
    tick(1);
    check("ack_ch0", 32'(alarm), 32'h0);
    ack = 3'b000;
    tick(6);
    check("acked_silent", 32'(alarm), 32'h0);
    sensor = 3'b000;
    tick(1);
    sensor = 3'b001;
    tick(3);
    check("rearm_edge3", 32'(alarm), 32'h0);
    tick(1);
    check("rearm_edge4", 32'(alarm), 32'h1);

    // Disarm with alarm=101.
    sensor = 3'b101;
    tick(4);
    check("pre_disarm", 32'(alarm), 32'h5);
    check("pre_disarm_top", 32'(top_id), 32'h0);
    arm = 1'b0;
    tick(1);
    check("disarm_alarm", 32'(alarm), 32'h0);
    check("disarm_any", 32'(any_alarm), 32'h0);
    tick(1);
    check("disarm_siren", 32'(siren), 32'h0);

    // Asynchronous reset with ch0 ACTIVE (siren high) and ch1 PENDING.
    arm    = 1'b1;
    sensor = 3'b001;
    tick(4);
    check("ar_alarm", 32'(alarm), 32'h1);
    sensor = 3'b011;
    tick(2);
    check("ar_siren_hi", 32'(siren), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("ar_alarm0", 32'(alarm), 32'h0);
    check("ar_siren0", 32'(siren), 32'h0);
    check("ar_any0", 32'(any_alarm), 32'h0);
    check("ar_top0", 32'(top_id), 32'h0);
    reset = 1'b1;
    // Counters were cleared: ch1 needs 4 fresh edges.
    tick(3);
    check("ar_cnt_clear", 32'(alarm), 32'h0);
    tick(1);
    check("ar_realarm", 32'(alarm), 32'h3);

    // Timeout behaviour on channel 2.
    sensor = 3'b000;
    ack    = 3'b011;
    tick(1);
    check("to_clear", 32'(alarm), 32'h0);
    ack    = 3'b000;
    sensor = 3'b100;
    tick(4);
    check("to_rise", 32'(alarm), 32'h4);
    sensor = 3'b000;
`ifdef ALARM_TIMEOUT_EN
    tick(15);
    check("to_edge15", 32'(alarm), 32'h4);
    tick(1);
    check("to_edge16", 32'(alarm), 32'h0);
`else
    tick(100);
    check("to_hold100", 32'(alarm), 32'h4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Parametrised, multi-channel successor to the fixed three-alarm (fire/burglar/rain) block in the smart-home design.
- Each channel debounces a raw sensor, latches an alarm, and waits for a per-channel acknowledge.
- A priority encoder reports the highest-priority active channel.
- A shared siren output blinks while any alarm is unacknowledged.

Parameters:
- NUM_ALARMS, 3: number of alarm channels. Channel 0 is highest priority (fire), then 1 (burglar), then 2 (rain).
- DEBOUNCE, 4: consecutive sampled-high cycles needed to raise an alarm. Must be at least 2.
- BLINK_HALF, 2: siren half-period, in clock cycles. Must be at least 1.
- ID_W, 2: width of top_id. Must satisfy 2^ID_W >= NUM_ALARMS.
- TIMEOUT, 16: auto-acknowledge delay in cycles. Used only when ALARM_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- arm  input  1  global enable. When low, all channels return to IDLE.
- sensor  input  NUM_ALARMS  raw sensor levels, one bit per channel.
- ack  input  NUM_ALARMS  per-channel acknowledge, level-sampled.
- alarm  output  NUM_ALARMS  registered; bit i is high while channel i is in ACTIVE.
- any_alarm  output  1  OR of alarm.
- top_id  output  ID_W  lowest index i with alarm[i]=1; 0 when none is active.
- siren  output  1  registered blink output.

Behaviour:
Reset (reset=0, asynchronous):
- All channels go to IDLE and all debounce counters to 0.
- alarm=0, siren=0, blink counter=0.
- Hence any_alarm=0 and top_id=0.
- Reset asserted mid-operation clears everything immediately, regardless of the clock.

Per-channel FSM, states IDLE, PENDING, ACTIVE, ACKED, 2-bit encoding, evaluated each rising edge:
- arm=0 forces every channel to IDLE with cnt=0. This overrides every rule below.
- IDLE: sensor[i]=1 goes to PENDING with cnt=1. Otherwise stay in IDLE.
- PENDING, sensor[i]=0: go to IDLE, cnt=0. A glitch shorter than DEBOUNCE cycles never alarms.
- PENDING, sensor[i]=1 and cnt==DEBOUNCE-1: go to ACTIVE, cnt=0.
- PENDING, sensor[i]=1 otherwise: cnt++.
- Resulting latency: alarm[i] rises on the DEBOUNCE-th consecutive rising edge that samples sensor[i]=1.
- ACTIVE is latched; the sensor falling does not clear it.
  - ack[i]=1 and sensor[i]=1: go to ACKED.
  - ack[i]=1 and sensor[i]=0: go to IDLE.
  - ack[i]=0: stay in ACTIVE.
- ACKED: sensor[i]=0 goes to IDLE; sensor[i]=1 stays in ACKED. A continuously high sensor therefore never re-alarms after acknowledge.
- ack[i] is ignored in IDLE, PENDING and ACKED.
- Channels are independent. Several may become ACTIVE in the same cycle.

Outputs:
- any_alarm and top_id are combinational from the registered alarm vector.
- Priority is fixed: the lowest index wins.

Siren, using a blink counter bcnt of width clog2(BLINK_HALF)+1:
- any_alarm=0: siren<=0, bcnt<=0.
- Otherwise, if bcnt==BLINK_HALF-1: siren<=~siren, bcnt<=0.
- Otherwise: bcnt++.
- The first siren rise occurs BLINK_HALF cycles after any_alarm rises.
- The siren is period 2*BLINK_HALF, 50% duty.
- Siren goes low on the edge after any_alarm falls.

Optional Feature:
- Macro: ALARM_TIMEOUT_EN.
- When defined: the channel counter is reused in ACTIVE and counts cycles.
  - When it reaches TIMEOUT-1 with no ack, the channel auto-acknowledges. It goes to ACKED if sensor[i]=1, else to IDLE.
  - An explicit ack on the same edge takes the same transition.
  - arm=0 still overrides.
- When undefined: ACTIVE holds indefinitely until ack[i] or arm=0. The counter is unused in ACTIVE and TIMEOUT is ignored.

Test Plan (defaults: NUM_ALARMS=3, DEBOUNCE=4, BLINK_HALF=2):
- Debounce rejection: arm=1, sensor=3'b001 for 3 cycles, then 3'b000 → alarm stays 3'b000 and siren stays 0.
- Debounce and latch: sensor=3'b010 held for 4 edges → alarm=3'b010 on the 4th edge, top_id=1. Dropping the sensor to 3'b000 keeps alarm=3'b010.
- Priority and siren: sensor=3'b110 held → alarm=3'b110 and top_id=1.
  - siren rises 2 cycles later and toggles every 2 cycles.
  - Then raise sensor[0] for 4 edges → alarm=3'b111, top_id=0.
- Acknowledge: with alarm=3'b001 and sensor[0]=1, pulse ack=3'b001 → alarm=3'b000, and the channel stays silent while sensor[0]=1.
  - Drop sensor[0] for 1 cycle, then raise it for 4 edges → alarm=3'b001 again.
- Disarm and reset: with alarm=3'b101, set arm=0 → alarm=3'b000 next edge and siren=0 one edge later.
  - Separately, assert reset=0 asynchronously mid-PENDING → all outputs 0 immediately, with no clock edge.
- Timeout (ALARM_TIMEOUT_EN defined): alarm[2] ACTIVE, no ack, sensor[2]=0 → alarm[2] clears exactly 16 cycles after rising.
  - With the macro undefined → alarm[2] remains high at 100 cycles.
